// File: rtl/iecdrv_sd_pkg.sv
// ============================================================================
// iecdrv_sd_pkg : shared types and constants for the SD request arbiter
// Revision      : 1.0
// ============================================================================
`default_nettype none

package iecdrv_sd_pkg;

    localparam int MAX_DRIVES = 4;
    localparam int TO_W       = 24;

    typedef enum logic [1:0] {
        SD_IDLE = 2'd0,
        SD_REQ  = 2'd1,
        SD_XFER = 2'd2,
        SD_DONE = 2'd3
    } sd_state_t;

endpackage

`default_nettype wire

// File: rtl/iecdrv_rr_pick.sv
// ============================================================================
// iecdrv_rr_pick : combinational round-robin picker, search starts at last+1
// Revision       : 1.0
// ============================================================================
`default_nettype none

module iecdrv_rr_pick
    import iecdrv_sd_pkg::*;
(
    input  logic [MAX_DRIVES-1:0] pending,
    input  logic [1:0]            last,
    output logic                  valid,
    output logic [1:0]            idx,
    output logic [MAX_DRIVES-1:0] onehot
);

    logic [1:0] cand;

    // Unused channels above NDR are tied low, so a mod-4 walk gives the
    // same order as a mod-NDR walk.
    always_comb begin
        valid  = 1'b0;
        idx    = 2'd0;
        cand   = 2'd0;
        for (int i = 1; i <= MAX_DRIVES; i++) begin
            cand = last + 2'(i);
            if (!valid && pending[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        onehot = valid ? (4'b0001 << idx) : 4'b0000;
    end

endmodule

`default_nettype wire

// File: rtl/iecdrv_sd_arbiter.sv
// ============================================================================
// iecdrv_sd_arbiter : round-robin mux of per-drive SD block requests onto host
// Revision          : 1.0
// ============================================================================
`default_nettype none

module iecdrv_sd_arbiter
    import iecdrv_sd_pkg::*;
#(
    parameter int             NDR         = 2,
    parameter logic [TO_W-1:0] ACK_TIMEOUT = 24'd8_000_000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       drv_lba      [NDR],
    input  logic [5:0]        drv_blk_cnt  [NDR],
    input  logic [NDR-1:0]    drv_rd,
    input  logic [NDR-1:0]    drv_wr,
    output logic [NDR-1:0]    drv_ack,
    input  logic [7:0]        drv_buff_din [NDR],
    output logic [31:0]       host_lba,
    output logic [5:0]        host_blk_cnt,
    output logic              host_rd,
    output logic              host_wr,
    output logic [1:0]        host_drive,
    input  logic              host_ack,
    output logic [7:0]        host_buff_din,
    output logic              busy,
    output logic [NDR-1:0]    timeout_err
);

    sd_state_t             state;
    sd_state_t             state_nx;
    logic [1:0]            last_grant;
    logic [1:0]            grant_idx;
    logic [MAX_DRIVES-1:0] grant_oh;
    logic                  op_rd;
    logic                  op_wr;
    logic [TO_W-1:0]       to_cnt;
    logic [MAX_DRIVES-1:0] pending;
    logic                  pick_valid;
    logic [1:0]            pick_idx;
    logic [MAX_DRIVES-1:0] pick_oh;
    logic [31:0]           sel_lba;
    logic [5:0]            sel_cnt;
    logic                  sel_rd;
    logic                  load_grant;
    logic                  to_fire;

    always_comb begin
        pending          = '0;
        pending[NDR-1:0] = drv_rd | drv_wr;
    end

    iecdrv_rr_pick u_pick (
        .pending (pending),
        .last    (last_grant),
        .valid   (pick_valid),
        .idx     (pick_idx),
        .onehot  (pick_oh)
    );

    always_comb begin
        sel_lba       = '0;
        sel_cnt       = '0;
        host_buff_din = '0;
        for (int i = 0; i < NDR; i++) begin
            if (pick_idx == 2'(i)) begin
                sel_lba = drv_lba[i];
                sel_cnt = drv_blk_cnt[i];
            end
            if (grant_idx == 2'(i)) begin
                host_buff_din = drv_buff_din[i];
            end
        end
    end

    assign sel_rd = |(drv_rd & pick_oh[NDR-1:0]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= SD_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_grant = 1'b0;
        to_fire    = 1'b0;
        case (state)
            SD_IDLE: begin
                if (pick_valid) begin
                    load_grant = 1'b1;
                    state_nx   = SD_REQ;
                end
            end
            SD_REQ: begin
                // An ack beats a simultaneous withdrawal or timeout.
                if (host_ack) begin
                    state_nx = SD_XFER;
                end else if ((pending & grant_oh) == '0) begin
                    state_nx = SD_IDLE;
                end else if (to_cnt >= ACK_TIMEOUT) begin
                    to_fire  = 1'b1;
                    state_nx = SD_IDLE;
                end
            end
            SD_XFER: begin
                if (!host_ack) begin
                    state_nx = SD_DONE;
                end
            end
            SD_DONE: state_nx = SD_IDLE;
            default: state_nx = SD_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            last_grant   <= 2'(NDR - 1);
            grant_idx    <= 2'd0;
            grant_oh     <= '0;
            op_rd        <= 1'b0;
            op_wr        <= 1'b0;
            host_lba     <= '0;
            host_blk_cnt <= '0;
            to_cnt       <= '0;
            timeout_err  <= '0;
        end else begin
            if (load_grant) begin
                grant_idx    <= pick_idx;
                grant_oh     <= pick_oh;
                host_lba     <= sel_lba;
                host_blk_cnt <= sel_cnt;
                op_rd        <= sel_rd;
                op_wr        <= !sel_rd;
                to_cnt       <= '0;
            end else if (state == SD_REQ && to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_fire) begin
                timeout_err <= timeout_err | grant_oh[NDR-1:0];
            end
            if (state == SD_DONE) begin
                last_grant <= grant_idx;
            end
        end
    end

    assign host_rd    = (state == SD_REQ) && op_rd;
    assign host_wr    = (state == SD_REQ) && op_wr;
    assign busy       = (state != SD_IDLE);
    assign host_drive = grant_idx;
    // Combinational so the first byte strobed alongside host_ack reaches the drive.
    assign drv_ack    = (host_ack && (state == SD_REQ || state == SD_XFER))
                        ? grant_oh[NDR-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_iecdrv_sd_arbiter.sv
// ============================================================================
// tb_iecdrv_sd_arbiter : self-checking bench for the SD request arbiter
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_iecdrv_sd_arbiter;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n;

    // 4-drive instance with a short ack timeout
    logic [31:0] lba   [4];
    logic [5:0]  bcnt  [4];
    logic [7:0]  bdin  [4];
    logic [3:0]  rd, wr, ack, to_err;
    logic [31:0] h_lba;
    logic [5:0]  h_cnt;
    logic        h_rd, h_wr, h_ack, busy;
    logic [1:0]  h_drv;
    logic [7:0]  h_din;

    // 2-drive instance with default timeout
    logic [31:0] lba2  [2];
    logic [5:0]  bcnt2 [2];
    logic [7:0]  bdin2 [2];
    logic [1:0]  rd2, wr2, ack2, to_err2;
    logic [31:0] h2_lba;
    logic [5:0]  h2_cnt;
    logic        h2_rd, h2_wr, h2_ack, busy2;
    logic [1:0]  h2_drv;
    logic [7:0]  h2_din;

    iecdrv_sd_arbiter #(.NDR(4), .ACK_TIMEOUT(24'd16)) u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .drv_lba(lba), .drv_blk_cnt(bcnt), .drv_rd(rd), .drv_wr(wr),
        .drv_ack(ack), .drv_buff_din(bdin),
        .host_lba(h_lba), .host_blk_cnt(h_cnt), .host_rd(h_rd), .host_wr(h_wr),
        .host_drive(h_drv), .host_ack(h_ack), .host_buff_din(h_din),
        .busy(busy), .timeout_err(to_err)
    );

    iecdrv_sd_arbiter #(.NDR(2)) u_dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .drv_lba(lba2), .drv_blk_cnt(bcnt2), .drv_rd(rd2), .drv_wr(wr2),
        .drv_ack(ack2), .drv_buff_din(bdin2),
        .host_lba(h2_lba), .host_blk_cnt(h2_cnt), .host_rd(h2_rd), .host_wr(h2_wr),
        .host_drive(h2_drv), .host_ack(h2_ack), .host_buff_din(h2_din),
        .busy(busy2), .timeout_err(to_err2)
    );

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic [1:0] exp_drv;
        logic       exp_rd;
        logic       exp_wr;
    } vec_t;

    vec_t       vecs [5];
    logic [1:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rd      = '0;
        wr      = '0;
        h_ack   = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!(h_rd || h_wr) && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 50) check("req_wait", {63'd0, h_rd | h_wr}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [1:0] e;

        vecs[0] = '{rd: 4'b0010, wr: 4'b0000, exp_drv: 2'd1, exp_rd: 1'b1, exp_wr: 1'b0};
        vecs[1] = '{rd: 4'b1000, wr: 4'b0100, exp_drv: 2'd2, exp_rd: 1'b0, exp_wr: 1'b1};
        vecs[2] = '{rd: 4'b0100, wr: 4'b0100, exp_drv: 2'd2, exp_rd: 1'b1, exp_wr: 1'b0};
        vecs[3] = '{rd: 4'b0000, wr: 4'b1001, exp_drv: 2'd0, exp_rd: 1'b0, exp_wr: 1'b1};
        vecs[4] = '{rd: 4'b1000, wr: 4'b0000, exp_drv: 2'd3, exp_rd: 1'b1, exp_wr: 1'b0};

        for (int i = 0; i < 4; i++) begin
            lba[i]  = 32'h1000_0000 + 32'(i) * 32'h111;
            bcnt[i] = 6'(i + 1);
            bdin[i] = 8'h00;
        end
        lba2[0] = 32'h0; lba2[1] = 32'h0; bcnt2[0] = '0; bcnt2[1] = '0;
        bdin2[0] = '0;   bdin2[1] = '0;   rd2 = '0; wr2 = '0; h2_ack = 1'b0;
        rd = '0; wr = '0; h_ack = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Two-drive instance: drive 1 alone
        lba2[1] = 32'h0000_0123;
        rd2     = 2'b10;
        @(negedge clk_sys);
        check("n2_host_rd", h2_rd, 1);
        check("n2_host_lba", h2_lba, 32'h123);
        check("n2_host_drive", h2_drv, 1);
        h2_ack = 1'b1;
        #1 check("n2_drv_ack", ack2, 2'b10);
        @(negedge clk_sys);
        check("n2_host_rd_clr", h2_rd, 0);
        rd2    = '0;
        h2_ack = 1'b0;

        // First grant from reset for each table vector
        for (int v = 0; v < 5; v++) begin
            do_reset();
            check("rst_busy", busy, 0);
            check("rst_host_rd_wr", {h_rd, h_wr}, 0);
            check("rst_host_lba", h_lba, 0);
            check("rst_timeout_err", to_err, 0);
            rd = vecs[v].rd;
            wr = vecs[v].wr;
            exp_q.push_back(vecs[v].exp_drv);
            @(negedge clk_sys);
            e = exp_q.pop_front();
            check("vec_drive", h_drv, e);
            check("vec_host_rd", h_rd, vecs[v].exp_rd);
            check("vec_host_wr", h_wr, vecs[v].exp_wr);
            check("vec_host_lba", h_lba, lba[e]);
            check("vec_host_cnt", h_cnt, bcnt[e]);
            rd = '0;
            wr = '0;
            @(negedge clk_sys);
        end

        // Round robin with drives 0, 2, 3 held
        do_reset();
        rd = 4'b1101;
        exp_q.push_back(2'd0); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        for (int k = 0; k < 4; k++) begin
            wait_req(n);
            if (k > 0) check("rr_turnaround", n, 3);
            e = exp_q.pop_front();
            check("rr_drive", h_drv, e);
            h_ack = 1'b1;
            #1 check("rr_drv_ack", ack, 4'b0001 << e);
            repeat (3) @(negedge clk_sys);
            h_ack = 1'b0;
        end
        rd = '0;
        repeat (3) @(negedge clk_sys);

        // Read and write together on drive 2
        do_reset();
        bdin[0] = 8'h5A;
        bdin[2] = 8'h11;
        rd = 4'b0100;
        wr = 4'b0100;
        wait_req(n);
        check("rw_first_rd", {h_rd, h_wr}, 2'b10);
        check("rw_first_drive", h_drv, 2);
        h_ack = 1'b1;
        @(negedge clk_sys);
        rd = '0;
        @(negedge clk_sys);
        h_ack = 1'b0;
        wait_req(n);
        check("rw_second_wr", {h_rd, h_wr}, 2'b01);
        check("rw_second_drive", h_drv, 2);
        check("rw_buff_din", h_din, 8'h11);
        bdin[2] = 8'hC3;
        #1 check("rw_buff_din_follow", h_din, 8'hC3);
        h_ack = 1'b1;
        @(negedge clk_sys);
        wr = '0;
        @(negedge clk_sys);
        h_ack = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Ack timeout on drive 1
        do_reset();
        rd = 4'b0010;
        wait_req(n);
        check("to_drive", h_drv, 1);
        repeat (16) @(negedge clk_sys);
        check("to_not_yet", to_err, 0);
        check("to_rd_held", h_rd, 1);
        @(negedge clk_sys);
        check("to_err_set", to_err, 4'b0010);
        check("to_rd_clr", h_rd, 0);
        wait_req(n);
        check("to_regrant_latency", n, 1);
        check("to_regrant_drive", h_drv, 1);
        rd = '0;
        @(negedge clk_sys);
        check("to_drop_idle", busy, 0);

        // Withdrawal in REQ
        rd = 4'b0001;
        wait_req(n);
        check("wd_drive", h_drv, 0);
        rd = '0;
        #1 check("wd_no_ack", ack, 0);
        @(negedge clk_sys);
        check("wd_idle", {busy, h_rd}, 0);
        check("wd_no_err", to_err, 4'b0010);

        // Withdrawal in XFER, then ack ignored in DONE/IDLE
        rd = 4'b0001;
        wait_req(n);
        h_ack = 1'b1;
        #1 check("xf_ack", ack, 4'b0001);
        @(negedge clk_sys);
        rd = '0;
        repeat (3) begin
            @(negedge clk_sys);
            check("xf_ack_held", ack, 4'b0001);
        end
        check("xf_busy", busy, 1);
        h_ack = 1'b0;
        #1 check("xf_ack_fall", ack, 0);
        @(negedge clk_sys);
        h_ack = 1'b1;
        #1 check("done_ack_ignored", ack, 0);
        @(negedge clk_sys);
        check("idle_ack_ignored", {busy, ack}, 0);
        h_ack = 1'b0;

        // Asynchronous reset during XFER
        rd = 4'b0100;
        wait_req(n);
        check("ar_drive", h_drv, 2);
        h_ack = 1'b1;
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("ar_rd_wr", {h_rd, h_wr}, 0);
        check("ar_busy", busy, 0);
        check("ar_ack", ack, 0);
        check("ar_drive_zero", h_drv, 0);
        check("ar_lba_cnt", {h_lba, h_cnt}, 0);
        check("ar_err", to_err, 0);
        h_ack = 1'b0;
        rd = 4'b0011;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("ar_first_drive", h_drv, 0);
        check("ar_first_rd", h_rd, 1);
        rd = '0;
        repeat (2) @(negedge clk_sys);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
